// File: rtl/dmem_mmio_responder_if.sv
// Processor data port, dmem syncram port and output stream of the MMIO responder.
interface dmem_mmio_responder_if;
  // processor side
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  // dmem syncram side
  logic [11:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;
  // output FIFO stream
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;

  modport slave (
    input  address_dmem, data, wren, mem_q, out_ready,
    output q_dmem, mem_address, mem_data, mem_wren, out_data, out_valid, overflow
  );

  modport master (
    output address_dmem, data, wren, mem_q, out_ready,
    input  q_dmem, mem_address, mem_data, mem_wren, out_data, out_valid, overflow
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: forwards ordinary accesses to dmem and serves a
// 256-word MMIO page (output FIFO, status, cycle counter, drop counter)
// with the same 1-cycle read latency as the syncram.
module dmem_mmio_responder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [3:0]  MMIO_PAGE  = 4'hF
) (
  input logic                  clock,
  input logic                  reset,
  dmem_mmio_responder_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [7:0] OFS_PUSH   = 8'h00;
  localparam logic [7:0] OFS_STATUS = 8'h01;
  localparam logic [7:0] OFS_CYCLES = 8'h02;
  localparam logic [7:0] OFS_DROPS  = 8'h03;

  logic          hit_c, mmio_wr_c, full_c, empty_c;
  logic          push_req_c, push_c, pop_c, drop_c;
  logic [7:0]    ofs_c;
  logic [DW-1:0] rd_c;

  logic [DW-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] cycles_q, cycles_d;
  logic [DW-1:0] drops_q, drops_d;
  logic          ovf_q, ovf_d;
  logic          sel_q;
  logic [DW-1:0] rdata_q;

  // Address decode and FIFO handshake; a pop frees a slot for a same-cycle push
  always_comb begin
    hit_c      = (bus.address_dmem[11:8] == MMIO_PAGE);
    ofs_c      = bus.address_dmem[7:0];
    mmio_wr_c  = bus.wren & hit_c;
    full_c     = (count_q == CW'(FIFO_DEPTH));
    empty_c    = (count_q == '0);
    pop_c      = ~empty_c & bus.out_ready;
    push_req_c = mmio_wr_c & (ofs_c == OFS_PUSH);
    push_c     = push_req_c & (~full_c | pop_c);
    drop_c     = push_req_c & ~push_c;
  end

  // dmem passthrough; the MMIO page never writes dmem
  assign bus.mem_address = bus.address_dmem;
  assign bus.mem_data    = bus.data;
  assign bus.mem_wren    = bus.wren & ~hit_c;

  // Register-map read mux, sampled from pre-update state
  always_comb begin
    rd_c = '0;
    unique case (ofs_c)
      OFS_STATUS: rd_c = {16'b0, 8'(count_q), 6'b0, full_c, empty_c};
      OFS_CYCLES: rd_c = cycles_q;
      OFS_DROPS:  rd_c = drops_q;
      default:    rd_c = '0;
    endcase
  end

  // Next-state for pointers, occupancy, counters and overflow flag
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(push_c) - CW'(pop_c);
    cycles_d = cycles_q + 32'd1;
    drops_d  = drops_q;
    ovf_d    = ovf_q;
    if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (mmio_wr_c && ofs_c == OFS_CYCLES) cycles_d = bus.data;
    if (mmio_wr_c && ofs_c == OFS_DROPS) drops_d = '0;
    else if (drop_c && drops_q != '1)    drops_d = drops_q + 32'd1;
    if (mmio_wr_c && ofs_c == OFS_STATUS && bus.data[0]) ovf_d = 1'b0;
    if (drop_c) ovf_d = 1'b1;
  end

  // Control and read-path state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      cycles_q <= '0;
      drops_q  <= '0;
      ovf_q    <= 1'b0;
      sel_q    <= 1'b1;
      rdata_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      cycles_q <= cycles_d;
      drops_q  <= drops_d;
      ovf_q    <= ovf_d;
      sel_q    <= hit_c;
      rdata_q  <= rd_c;
    end
  end

  // FIFO storage; cleared on reset so out_data reads 0 afterwards
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else if (push_c) begin
      fifo_q[wr_ptr_q] <= bus.data;
    end
  end

  assign bus.q_dmem    = sel_q ? rdata_q : bus.mem_q;
  assign bus.out_data  = fifo_q[rd_ptr_q];
  assign bus.out_valid = ~empty_c;
  assign bus.overflow  = ovf_q;

endmodule
